inst_constraint: RTL and testbench
==================================

// Module: inst_constraint
// PURPOSE
//  Instruction-legality checker for the SQED formal harness on the RISC-V core.
//  Decodes a 32-bit fetched instruction and flags whether it belongs to the
//  allowed "original" subset: RV32I ALU, RV32M multiply, LUI, and LW/SW.
//  That subset only uses architectural registers x0..x15 and data-memory words 0..31.
//  Two instances sit beside the pipeline, one per fetch slot; formal constrains legal==1 each cycle.
// PARAMETERS
//  CNT_W   16   width of the saturating illegal-instruction counter
// PORTS
//  clk            in   1      clock; all state updates on rising edge
//  rst            in   1      synchronous, active-high reset
//  instruction    in   32     fetched instruction word (RV32 encoding)
//  legal          out  1      combinational: instruction is in the allowed subset
//  inst_class     out  3      combinational: class code of instruction (0 when illegal)
//  illegal_seen   out  1      registered sticky: some illegal word sampled since reset
//  illegal_count  out  CNT_W  registered saturating count of illegal cycles
// BEHAVIOUR
//  Reset: one clock and one synchronous active-high reset, rst; clock port is clk.
//   - While rst=1 at a rising edge: illegal_seen<=0, illegal_count<=0.
//   - legal and inst_class are purely combinational and are unaffected by rst.
//  Field split:
//   - op=[6:0], rd=[11:7], f3=[14:12], rs1=[19:15], rs2=[24:20], f7=[31:25].
//  Register rule:
//   - Every register field the class actually uses must have bit 4 = 0 (x0..x15).
//   - Unused fields are don't-care.
//  inst_class codes:
//   - 0 ILLEGAL, 1 ALU_REG, 2 ALU_IMM, 3 MUL, 4 LOAD, 5 STORE, 6 LUI; 7 never produced.
//  Legal encodings:
//   - ALU_REG, op=0110011, f7=0000000: any f3 (ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND).
//     Also f7=0100000 with f3 in {000,101} (SUB/SRA). Uses rd, rs1, rs2.
//   - MUL, op=0110011, f7=0000001, f3 in {000..011}: MUL/MULH/MULHSU/MULHU.
//     f3 in {100..111} (DIV/REM) is illegal. Uses rd, rs1, rs2.
//   - ALU_IMM, op=0010011: f3 in {000,010,011,100,110,111} with any immediate.
//     f3=001 requires f7=0000000 (SLLI). f3=101 requires f7 in {0000000,0100000} (SRLI/SRAI).
//     Uses rd, rs1.
//   - LOAD, op=0000011, f3=010 (LW only): rs1 must equal 0 and inst[31:25] must be 0.
//     This gives immediate 0..31, i.e. the original memory half. Uses rd.
//   - STORE, op=0100011, f3=010 (SW only): rs1 must equal 0 and inst[31:25] must be 0.
//     inst[11:7] is free. Uses rs2.
//   - LUI, op=0110111: uses rd.
//  Everything else is ILLEGAL: branches, JAL/JALR, AUIPC, FENCE, SYSTEM, custom opcodes
//  (e.g. 0x77), other load/store widths, and any rs/rd >= 16.
//  rd=x0 is legal (NOP form; e.g. 0x00000013 -> ALU_IMM).
//  Sequential update, each rising edge when rst=0:
//   - If legal=0: illegal_seen<=1, and illegal_count<=illegal_count+1.
//     The count saturates at all-ones and never wraps.
//   - If legal=1: both registers hold.
//  Latency: legal/inst_class have zero latency; the registered outputs lag by 1 cycle.
//  If rst and an illegal word occur in the same cycle, rst wins (both outputs become 0).
//  X on instruction is treated as don't-care; no X-propagation handling is required.
// TESTING
//  1. 0x00700093 (addi x1,x0,7) -> legal=1, class=2; next cycle illegal_seen stays 0.
//  2. 0x00708193 (addi x3,x1,7) -> class=2.
//     0x00F02383 (lw x7,15(x0)) -> class=4.
//     0x022081B3 (mul x3,x1,x2) -> class=3.
//  3. 0x007000F7 (opcode 0x77) -> legal=0, class=0; next cycle illegal_seen=1, count=1.
//     Holding it 3 more cycles -> count=4.
//  4. 0x011100B3 (add x1,x2,x17) -> illegal. 0x02000FB3 (mul x31,...) -> illegal.
//     0x02F02383 (lw, imm=47) -> illegal. 0x0000A383 (lw rs1=x1) -> illegal.
//  5. Count set to 0xFFFE then illegal for 3 cycles -> 0xFFFF and held.
//     rst=1 with illegal input -> count=0, illegal_seen=0 next cycle.
//  6. Sweep all 128 opcodes with zeroed other fields.
//     Only 0x03, 0x13, 0x23, 0x33, 0x37 may report legal, and 0x03/0x23 need f3=010.

Source files
------------

// File: rtl/inst_constraint.sv
// rtl/inst_constraint.sv - legality checker for fetched RV32 words in the SQED harness
module inst_constraint #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instruction,
    output logic             legal,
    output logic [2:0]       inst_class,
    output logic             illegal_seen,
    output logic [CNT_W-1:0] illegal_count
);

    localparam logic [2:0] C_ILLEGAL = 3'd0;
    localparam logic [2:0] C_ALU_REG = 3'd1;
    localparam logic [2:0] C_ALU_IMM = 3'd2;
    localparam logic [2:0] C_MUL     = 3'd3;
    localparam logic [2:0] C_LOAD    = 3'd4;
    localparam logic [2:0] C_STORE   = 3'd5;
    localparam logic [2:0] C_LUI     = 3'd6;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [6:0]       w_op;
    logic [4:0]       w_rd;
    logic [2:0]       w_f3;
    logic [4:0]       w_rs1;
    logic [4:0]       w_rs2;
    logic [6:0]       w_f7;
    logic             w_rd_ok;
    logic             w_rs1_ok;
    logic             w_rs2_ok;
    logic [2:0]       w_class;
    logic             r_seen;
    logic [CNT_W-1:0] r_count;

    assign w_op  = instruction[6:0];
    assign w_rd  = instruction[11:7];
    assign w_f3  = instruction[14:12];
    assign w_rs1 = instruction[19:15];
    assign w_rs2 = instruction[24:20];
    assign w_f7  = instruction[31:25];

    // Original subset only touches x0..x15, so bit 4 of every used field must be clear.
    assign w_rd_ok  = ~w_rd[4];
    assign w_rs1_ok = ~w_rs1[4];
    assign w_rs2_ok = ~w_rs2[4];

    always_comb begin
        w_class = C_ILLEGAL;
        case (w_op)
            7'b0110011: begin
                if (w_rd_ok && w_rs1_ok && w_rs2_ok) begin
                    if (w_f7 == 7'b0000000)
                        w_class = C_ALU_REG;
                    else if (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101))
                        w_class = C_ALU_REG;
                    else if (w_f7 == 7'b0000001 && !w_f3[2])
                        w_class = C_MUL;
                end
            end
            7'b0010011: begin
                if (w_rd_ok && w_rs1_ok) begin
                    if (w_f3 == 3'b001) begin
                        if (w_f7 == 7'b0000000)
                            w_class = C_ALU_IMM;
                    end else if (w_f3 == 3'b101) begin
                        if (w_f7 == 7'b0000000 || w_f7 == 7'b0100000)
                            w_class = C_ALU_IMM;
                    end else begin
                        w_class = C_ALU_IMM;
                    end
                end
            end
            // Base x0 with imm[11:5]=0 confines LW/SW to data words 0..31.
            7'b0000011: begin
                if (w_f3 == 3'b010 && w_rs1 == 5'd0 && w_f7 == 7'd0 && w_rd_ok)
                    w_class = C_LOAD;
            end
            7'b0100011: begin
                if (w_f3 == 3'b010 && w_rs1 == 5'd0 && w_f7 == 7'd0 && w_rs2_ok)
                    w_class = C_STORE;
            end
            7'b0110111: begin
                if (w_rd_ok)
                    w_class = C_LUI;
            end
            default: w_class = C_ILLEGAL;
        endcase
    end

    assign inst_class = w_class;
    assign legal      = (w_class != C_ILLEGAL);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seen  <= 1'b0;
            r_count <= '0;
        end else if (!legal) begin
            r_seen <= 1'b1;
            if (r_count != CNT_MAX)
                r_count <= r_count + CNT_ONE;
        end
    end

    assign illegal_seen  = r_seen;
    assign illegal_count = r_count;

endmodule

// File: tb/tb_inst_constraint.sv
// tb/tb_inst_constraint.sv - directed bench for inst_constraint
module tb_inst_constraint;

    logic        clk;
    logic        rst;
    logic [31:0] instruction;
    logic        legal;
    logic [2:0]  inst_class;
    logic        illegal_seen;
    logic [15:0] illegal_count;

    int          checks;
    int          errors;
    logic        exp_seen;
    logic [15:0] exp_count;

    inst_constraint #(.CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .instruction  (instruction),
        .legal        (legal),
        .inst_class   (inst_class),
        .illegal_seen (illegal_seen),
        .illegal_count(illegal_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_comb(input string tag, input logic exp_legal, input logic [2:0] exp_class);
        checks++;
        assert (legal === exp_legal) else begin
            errors++;
            $error("FAIL %s legal: got %0b expected %0b", tag, legal, exp_legal);
        end
        checks++;
        assert (inst_class === exp_class) else begin
            errors++;
            $error("FAIL %s class: got %0d expected %0d", tag, inst_class, exp_class);
        end
    endtask

    task automatic check_regs(input string tag);
        checks++;
        assert (illegal_seen === exp_seen) else begin
            errors++;
            $error("FAIL %s seen: got %0b expected %0b", tag, illegal_seen, exp_seen);
        end
        checks++;
        assert (illegal_count === exp_count) else begin
            errors++;
            $error("FAIL %s count: got %h expected %h", tag, illegal_count, exp_count);
        end
    endtask

    // Reference for the sticky flag and saturating counter over one clock edge.
    task automatic model_edge(input logic was_legal);
        if (rst) begin
            exp_seen  = 1'b0;
            exp_count = 16'h0000;
        end else if (!was_legal) begin
            exp_seen = 1'b1;
            if (exp_count != 16'hFFFF)
                exp_count = exp_count + 16'h0001;
        end
    endtask

    task automatic apply(input string tag, input logic [31:0] instr,
                         input logic exp_legal, input logic [2:0] exp_class);
        instruction = instr;
        #1;
        check_comb(tag, exp_legal, exp_class);
        @(posedge clk);
        model_edge(exp_legal);
        #1;
        check_regs(tag);
    endtask

    task automatic hold_illegal(input int n);
        instruction = 32'h007000F7;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge(1'b0);
        end
        #1;
    endtask

    initial begin
        logic [6:0] op;
        logic       sw_legal;
        logic [2:0] sw_class;
        int         n;

        checks      = 0;
        errors      = 0;
        exp_seen    = 1'b0;
        exp_count   = 16'h0000;
        rst         = 1'b1;
        instruction = 32'h007000F7;
        repeat (2) @(posedge clk);
        #1;
        check_regs("reset");
        rst = 1'b0;

        apply("addi_x1", 32'h00700093, 1'b1, 3'd2);
        apply("addi_x3", 32'h00708193, 1'b1, 3'd2);
        apply("lw_15",   32'h00F02383, 1'b1, 3'd4);
        apply("mul",     32'h022081B3, 1'b1, 3'd3);
        apply("sub",     32'h40000033, 1'b1, 3'd1);
        apply("srai",    32'h40005013, 1'b1, 3'd2);
        apply("sw_x2",   32'h00202023, 1'b1, 3'd5);
        apply("lui_x1",  32'h000100B7, 1'b1, 3'd6);
        apply("nop",     32'h00000013, 1'b1, 3'd2);

        apply("op77",    32'h007000F7, 1'b0, 3'd0);
        hold_illegal(3);
        check_regs("op77_hold");

        apply("add_x17",  32'h011100B3, 1'b0, 3'd0);
        apply("mul_x31",  32'h02000FB3, 1'b0, 3'd0);
        apply("lw_47",    32'h02F02383, 1'b0, 3'd0);
        apply("lw_rs1",   32'h0000A383, 1'b0, 3'd0);
        apply("f7_sll",   32'h40001033, 1'b0, 3'd0);
        apply("div",      32'h02004033, 1'b0, 3'd0);
        apply("slli_bad", 32'h40001013, 1'b0, 3'd0);
        apply("sw_x16",   32'h01002023, 1'b0, 3'd0);
        apply("lui_x16",  32'h00010837, 1'b0, 3'd0);
        apply("lb",       32'h00000003, 1'b0, 3'd0);

        n = int'(16'hFFFE - exp_count);
        hold_illegal(n);
        check_regs("sat_fffe");
        hold_illegal(3);
        check_regs("sat_hold");

        rst = 1'b1;
        instruction = 32'h007000F7;
        @(posedge clk);
        model_edge(1'b0);
        #1;
        check_regs("rst_wins");

        // Registers stay in reset while the opcode sweep exercises the decoder.
        for (int i = 0; i < 128; i++) begin
            op = 7'(i);
            instruction = {25'd0, op};
            #1;
            sw_legal = 1'b0;
            sw_class = 3'd0;
            if (op == 7'h13) begin sw_legal = 1'b1; sw_class = 3'd2; end
            if (op == 7'h33) begin sw_legal = 1'b1; sw_class = 3'd1; end
            if (op == 7'h37) begin sw_legal = 1'b1; sw_class = 3'd6; end
            check_comb($sformatf("sweep_%02h", op), sw_legal, sw_class);
        end
        instruction = 32'h00002003;
        #1;
        check_comb("sweep_lw_f3", 1'b1, 3'd4);
        instruction = 32'h00002023;
        #1;
        check_comb("sweep_sw_f3", 1'b1, 3'd5);

        @(posedge clk);
        #1;
        rst = 1'b0;
        apply("post_rst", 32'h00700093, 1'b1, 3'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
